// File: rtl/instruction_fetch_queue.sv
// Fetch queue between the PC and decode: issues word reads to a synchronous
// instruction memory and buffers returned {pc, instruction} pairs for decode.
module instruction_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [ADDR_W-1:0]          pc_in,
  input  logic                       pc_valid,
  output logic                       fetch_stall,
  input  logic                       flush,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [DATA_W-1:0]          instr_out,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_pc;
  logic [CW:0]       occupancy;
  logic              accept;
  logic              push;
  logic              pop;

  // The in-flight read reserves a slot, so a push can never land on a full FIFO.
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, pend_v};
  assign fetch_stall = (occupancy >= (CW+1)'(DEPTH));

  assign accept    = pc_valid & ~fetch_stall & ~flush;
  assign imem_req  = accept;
  assign imem_addr = pc_in;

  assign instr_valid = (count != '0);
  assign instr_out   = mem_instr[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];

  assign push = pend_v & ~flush;
  assign pop  = instr_valid & instr_ready & ~flush;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      pend_v  <= accept;
      pend_pc <= pc_in;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (push) begin
      mem_pc[wr_ptr]    <= pend_pc;
      mem_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_instruction_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              Clock = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              fetch_stall;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic [CW-1:0]     count;

  int n_checks = 0;
  int n_fails  = 0;
  logic dead = 1'b0;

  instruction_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock(Clock), .Reset(Reset), .pc_in(pc_in), .pc_valid(pc_valid),
    .fetch_stall(fetch_stall), .flush(flush), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .count(count)
  );

  always #5 Clock = ~Clock;

  // Synchronous memory: word = 0xA000_0000 + address, garbage when idle.
  always @(posedge Clock)
    imem_rdata <= dead ? 32'hDEAD_BEEF
                       : (imem_req ? 32'hA000_0000 + imem_addr : $urandom);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ins;
  } entry_t;

  entry_t            m_q[$];
  bit                m_pend;
  logic [ADDR_W-1:0] m_pend_pc;

  function automatic bit m_stall();
    return (m_q.size() + int'(m_pend)) >= DEPTH;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_pend = 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic tick();
    bit acc;
    bit do_pop;
    acc = pc_valid && !m_stall() && !flush;
    if (flush) begin
      m_q.delete();
      m_pend = 0;
    end else begin
      do_pop = (m_q.size() != 0) && instr_ready;
      if (do_pop) void'(m_q.pop_front());
      if (m_pend) m_q.push_back('{pc: m_pend_pc, ins: 32'hA000_0000 + m_pend_pc});
      m_pend    = acc;
      m_pend_pc = pc_in;
    end
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic drive(input bit pv, input logic [ADDR_W-1:0] pc,
                       input bit rdy, input bit fl);
    pc_valid    = pv;
    pc_in       = pc;
    instr_ready = rdy;
    flush       = fl;
    #1;
  endtask

  // Structural invariants that must hold every cycle.
  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      n_checks++;
      if (count > CW'(DEPTH)) begin
        n_fails++;
        $display("FAIL overflow: count=%0d exceeds %0d", count, DEPTH);
      end
      n_checks++;
      if (count == CW'(DEPTH) && fetch_stall !== 1'b1) begin
        n_fails++;
        $display("FAIL full_stall: fetch_stall=%b required 1 at count=%0d", fetch_stall, count);
      end
    end
  end

  task automatic test_reset();
    Reset = 1'b0;
    dead  = 1'b0;
    pc_valid = 0; pc_in = '0; instr_ready = 0; flush = 0;
    #3;
    n_checks++;
    if ({instr_valid, fetch_stall, imem_req} !== 3'b000 || count !== '0) begin
      n_fails++;
      $display("FAIL reset_ctrl: valid=%b stall=%b req=%b count=%0d required 0", instr_valid, fetch_stall, imem_req, count);
    end
    n_checks++;
    if (instr_out !== '0 || instr_pc !== '0) begin
      n_fails++;
      $display("FAIL reset_data: out=%h pc=%h required 0", instr_out, instr_pc);
    end
    @(negedge Clock);
    Reset = 1'b1;
    m_reset();
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      drive(k < 4, ADDR_W'(k), 1'b1, 1'b0);
      n_checks++;
      if (instr_valid !== (k >= 2 && k < 6)) begin
        n_fails++;
        $display("FAIL stream_valid[%0d]: got %b", k, instr_valid);
      end
      if (k >= 2 && k < 6) begin
        n_checks++;
        if (instr_pc !== ADDR_W'(k - 2) || instr_out !== 32'hA000_0000 + DATA_W'(k - 2)) begin
          n_fails++;
          $display("FAIL stream_data[%0d]: pc=%h out=%h required pc=%h", k, instr_pc, instr_out, k - 2);
        end
      end
      n_checks++;
      if (fetch_stall !== 1'b0 || imem_req !== (k < 4)) begin
        n_fails++;
        $display("FAIL stream_issue[%0d]: stall=%b req=%b", k, fetch_stall, imem_req);
      end
      tick();
    end
  endtask

  task automatic test_fill_stall(input logic [ADDR_W-1:0] base);
    int pulses = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, base + ADDR_W'(k), 1'b0, 1'b0);
      if (imem_req === 1'b1) pulses++;
      n_checks++;
      if (fetch_stall !== m_stall()) begin
        n_fails++;
        $display("FAIL fill_stall[%0d]: got %b required %b", k, fetch_stall, m_stall());
      end
      tick();
    end
    n_checks++;
    if (pulses != DEPTH) begin
      n_fails++;
      $display("FAIL fill_pulses: got %0d required %0d", pulses, DEPTH);
    end
    n_checks++;
    if (count !== CW'(DEPTH)) begin
      n_fails++;
      $display("FAIL fill_count: got %0d required %0d", count, DEPTH);
    end
  endtask

  task automatic test_drain(input logic [ADDR_W-1:0] base);
    int popped = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (k < 2) begin
        n_checks++;
        if (fetch_stall !== (k == 0)) begin
          n_fails++;
          $display("FAIL drain_stall[%0d]: got %b required %b", k, fetch_stall, k == 0);
        end
      end
      if (instr_valid === 1'b1) begin
        n_checks++;
        if (instr_pc !== base + ADDR_W'(popped) || instr_out !== 32'hA000_0000 + base + ADDR_W'(popped)) begin
          n_fails++;
          $display("FAIL drain_order: pc=%h out=%h required pc=%h", instr_pc, instr_out, base + ADDR_W'(popped));
        end
        popped++;
      end
      tick();
    end
    n_checks++;
    if (popped != DEPTH || count !== '0) begin
      n_fails++;
      $display("FAIL drain_total: popped=%0d count=%0d required %0d and 0", popped, count, DEPTH);
    end
  endtask

  task automatic test_flush_pending();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h100 + ADDR_W'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h103, 1'b0, 1'b1);
    dead = 1'b1;
    n_checks++;
    if (count !== CW'(2) || imem_req !== 1'b0) begin
      n_fails++;
      $display("FAIL flush_setup: count=%0d req=%b required 2 and 0", count, imem_req);
    end
    tick();
    dead = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(k == 0, 32'h200, 1'b1, 1'b0);
      if (k < 2) begin
        n_checks++;
        if (instr_valid !== 1'b0 || count !== '0) begin
          n_fails++;
          $display("FAIL flush_empty[%0d]: valid=%b count=%0d required 0", k, instr_valid, count);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_out !== 32'hA000_0200) begin
          n_fails++;
          $display("FAIL flush_refetch: valid=%b pc=%h out=%h required 1 200 a0000200", instr_valid, instr_pc, instr_out);
        end
      end
      n_checks++;
      if (instr_valid === 1'b1 && instr_out === 32'hDEAD_BEEF) begin
        n_fails++;
        $display("FAIL flush_leak: out=%h must not be emitted", instr_out);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] next_pc = 32'h300;
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(k < 3, 32'h300 + ADDR_W'(k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(3)) begin
      n_fails++;
      $display("FAIL wrap_setup: count=%0d required 3", count);
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h303 + ADDR_W'(k), 1'b1, 1'b0);
      n_checks++;
      if (count !== CW'(m_q.size()) || instr_pc !== next_pc || instr_out !== 32'hA000_0000 + next_pc) begin
        n_fails++;
        $display("FAIL wrap_order[%0d]: count=%0d pc=%h out=%h required %0d %h", k, count, instr_pc, instr_out, m_q.size(), next_pc);
      end
      next_pc++;
      tick();
    end
  endtask

  task automatic test_random();
    bit exp_stall;
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      exp_stall = m_stall();
      n_checks++;
      if (count !== CW'(m_q.size()) || instr_valid !== (m_q.size() != 0) || fetch_stall !== exp_stall) begin
        n_fails++;
        $display("FAIL rand_ctrl[%0d]: count=%0d valid=%b stall=%b required %0d %b %b", k, count, instr_valid, fetch_stall, m_q.size(), m_q.size() != 0, exp_stall);
      end
      n_checks++;
      if (imem_req !== (pc_valid && !exp_stall && !flush) || imem_addr !== pc_in) begin
        n_fails++;
        $display("FAIL rand_issue[%0d]: req=%b addr=%h", k, imem_req, imem_addr);
      end
      if (m_q.size() != 0) begin
        n_checks++;
        if (instr_pc !== m_q[0].pc || instr_out !== m_q[0].ins) begin
          n_fails++;
          $display("FAIL rand_head[%0d]: pc=%h out=%h required %h %h", k, instr_pc, instr_out, m_q[0].pc, m_q[0].ins);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(k < 3, 32'h400 + ADDR_W'(k), 1'b0, 1'b0);
      tick();
    end
    n_checks++;
    if (count !== CW'(3)) begin
      n_fails++;
      $display("FAIL areset_setup: count=%0d required 3", count);
    end
    #1 Reset = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || count !== '0 || fetch_stall !== 1'b0) begin
      n_fails++;
      $display("FAIL areset_clear: valid=%b count=%0d stall=%b required 0", instr_valid, count, fetch_stall);
    end
    #1;
    Reset    = 1'b1;
    m_reset();
    pc_valid = 1'b1;
    pc_in    = 32'h500;
    #1;
    n_checks++;
    if (imem_req !== 1'b1) begin
      n_fails++;
      $display("FAIL areset_accept: req=%b required 1", imem_req);
    end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h500) begin
      n_fails++;
      $display("FAIL areset_resume: valid=%b pc=%h required 1 500", instr_valid, instr_pc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_stall(32'h40);
    test_drain(32'h40);
    test_flush_pending();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
